// File: rtl/dram_sched_pkg.sv
// ============================================================================
// Module : dram_sched_pkg
// Brief  : Shared constants and state type for the DRAM access scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dram_sched_pkg;

    localparam int PH_W     = 4;
    localparam int SLOT_LEN = 1 << PH_W;

    // Bit p of each mask is the value the strobe takes (active) in phase p.
    localparam logic [SLOT_LEN-1:0] VID_RAS_PH   = 16'h00EE;
    localparam logic [SLOT_LEN-1:0] VID_CAS_PH   = 16'h00CC;
    localparam logic [SLOT_LEN-1:0] VID_LATCH_PH = 16'h0088;
    localparam logic [SLOT_LEN-1:0] CCLK_PH      = 16'h00FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAITC  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/dram_access_scheduler_if.sv
// ============================================================================
// Module : dram_sched_if
// Brief  : CPU handshake and DRAM/video strobe bundle of the scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dram_sched_if;
    import dram_sched_pkg::*;

    logic            MREQ_n;
    logic            RD_n;
    logic            WR_n;
    logic            RAS_n;
    logic            CAS_n;
    logic            MWE_n;
    logic            ADDR_SEL;
    logic            VID_LATCH;
    logic            CCLK;
    logic            WAIT_n;
    logic [PH_W-1:0] SLOT_PH;

    modport master (
        output MREQ_n, RD_n, WR_n,
        input  RAS_n, CAS_n, MWE_n, ADDR_SEL, VID_LATCH, CCLK, WAIT_n, SLOT_PH
    );

    modport slave (
        input  MREQ_n, RD_n, WR_n,
        output RAS_n, CAS_n, MWE_n, ADDR_SEL, VID_LATCH, CCLK, WAIT_n, SLOT_PH
    );

endinterface

`default_nettype wire

// File: rtl/dram_phase_gen.sv
// ============================================================================
// Module : dram_phase_gen
// Brief  : Slot phase counter with video fetch strobe decode, CCLK and latch.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_phase_gen
    import dram_sched_pkg::*;
(
    input  wire             CLK_n,
    input  wire             RESET_n,
    output logic [PH_W-1:0] ph,
    output logic [PH_W-1:0] ph_nxt,
    output logic            vid_ras_nxt,
    output logic            vid_cas_nxt,
    output logic            vid_latch,
    output logic            cclk
);

    logic [PH_W-1:0] r_ph;
    logic            r_vid_latch;
    logic            r_cclk;

    // Strobes are decoded from the next phase so registered outputs line up with ph.
    assign ph_nxt      = r_ph + PH_W'(1);
    assign vid_ras_nxt = VID_RAS_PH[ph_nxt];
    assign vid_cas_nxt = VID_CAS_PH[ph_nxt];

    always_ff @(posedge CLK_n or negedge RESET_n) begin
        if (!RESET_n) begin
            r_ph        <= '0;
            r_vid_latch <= 1'b0;
            r_cclk      <= 1'b0;
        end else begin
            r_ph        <= ph_nxt;
            r_vid_latch <= VID_LATCH_PH[ph_nxt];
            r_cclk      <= CCLK_PH[ph_nxt];
        end
    end

    assign ph        = r_ph;
    assign vid_latch = r_vid_latch;
    assign cclk      = r_cclk;

endmodule

`default_nettype wire

// File: rtl/dram_access_scheduler.sv
// ============================================================================
// Module : dram_access_scheduler
// Brief  : Time-slots video DRAM between CRTC fetches and a Z80 CPU window.
//          DRAM_SCHED_STALL_CNT_EN adds a saturating CPU stall counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_access_scheduler
    import dram_sched_pkg::*;
#(
    parameter int CPU_WIN_START = 8,
    parameter int CPU_WIN_LEN   = 6
`ifdef DRAM_SCHED_STALL_CNT_EN
    ,
    parameter int STALL_W       = 16
`endif
)(
    input  wire          CLK_n,
    input  wire          RESET_n,
    dram_sched_if.slave  bus
`ifdef DRAM_SCHED_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] STALL_CNT
`endif
);

    localparam logic [PH_W-1:0] c_WIN_OPEN_PH  = PH_W'(CPU_WIN_START - 1);
    localparam logic [PH_W-1:0] c_WIN_FIRST_PH = PH_W'(CPU_WIN_START);
    localparam logic [PH_W-1:0] c_WIN_LAST_PH  = PH_W'(CPU_WIN_START + CPU_WIN_LEN - 1);

    logic [PH_W-1:0] w_ph;
    logic [PH_W-1:0] w_ph_nxt;
    logic [PH_W-1:0] w_win_idx;
    logic            w_vid_ras_nxt;
    logic            w_vid_cas_nxt;
    logic            w_vid_latch;
    logic            w_cclk;

    sched_state_t    r_state;
    sched_state_t    w_state_nxt;
    logic            w_req;
    logic            w_acc_nxt;
    logic            w_enter;
    logic            w_wr_nxt;
    logic            r_wr;
    logic            r_ras_n;
    logic            r_cas_n;
    logic            r_mwe_n;
    logic            r_addr_sel;
    logic            r_wait_n;

    dram_phase_gen u_phase_gen (
        .CLK_n       (CLK_n),
        .RESET_n     (RESET_n),
        .ph          (w_ph),
        .ph_nxt      (w_ph_nxt),
        .vid_ras_nxt (w_vid_ras_nxt),
        .vid_cas_nxt (w_vid_cas_nxt),
        .vid_latch   (w_vid_latch),
        .cclk        (w_cclk)
    );

    assign w_req = ~bus.MREQ_n & (~bus.RD_n | ~bus.WR_n);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req && (w_ph == c_WIN_OPEN_PH)) w_state_nxt = ACCESS;
                else if (w_req)                        w_state_nxt = WAITC;
            end
            WAITC: begin
                if (!w_req)                     w_state_nxt = IDLE;
                else if (w_ph == c_WIN_OPEN_PH) w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (w_ph == c_WIN_LAST_PH) w_state_nxt = DONE;
            end
            DONE: begin
                if (bus.MREQ_n) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Write flag is frozen on window entry; simultaneous RD/WR resolves to read.
    assign w_acc_nxt = (w_state_nxt == ACCESS);
    assign w_enter   = w_acc_nxt && (r_state != ACCESS);
    assign w_wr_nxt  = w_enter ? (~bus.WR_n & bus.RD_n) : r_wr;
    assign w_win_idx = w_ph_nxt - c_WIN_FIRST_PH;

    always_ff @(posedge CLK_n or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= IDLE;
            r_wr       <= 1'b0;
            r_ras_n    <= 1'b1;
            r_cas_n    <= 1'b1;
            r_mwe_n    <= 1'b1;
            r_addr_sel <= 1'b0;
            r_wait_n   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_wr       <= w_wr_nxt;
            r_ras_n    <= ~(w_vid_ras_nxt | w_acc_nxt);
            r_cas_n    <= ~(w_vid_cas_nxt | (w_acc_nxt && (w_win_idx != '0)));
            r_mwe_n    <= ~(w_acc_nxt && (w_win_idx >= PH_W'(2)) && w_wr_nxt);
            r_addr_sel <= w_acc_nxt;
            r_wait_n   <= ~((w_state_nxt == WAITC) || w_acc_nxt);
        end
    end

    assign bus.RAS_n     = r_ras_n;
    assign bus.CAS_n     = r_cas_n;
    assign bus.MWE_n     = r_mwe_n;
    assign bus.ADDR_SEL  = r_addr_sel;
    assign bus.WAIT_n    = r_wait_n;
    assign bus.VID_LATCH = w_vid_latch;
    assign bus.CCLK      = w_cclk;
    assign bus.SLOT_PH   = w_ph;

`ifdef DRAM_SCHED_STALL_CNT_EN
    logic [STALL_W-1:0] r_stall_cnt;

    always_ff @(posedge CLK_n or negedge RESET_n) begin
        if (!RESET_n) begin
            r_stall_cnt <= '0;
        end else if (!r_wait_n && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    assign STALL_CNT = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dram_access_scheduler.sv
// ============================================================================
// Module : tb_dram_access_scheduler
// Brief  : Directed and random stimulus against a slot-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_access_scheduler;
    import dram_sched_pkg::*;

    localparam int WS = 8;
    localparam int WL = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dram_sched_if bus ();

`ifdef DRAM_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    dram_access_scheduler #(
        .CPU_WIN_START (WS),
        .CPU_WIN_LEN   (WL)
    ) dut (
        .CLK_n   (clk),
        .RESET_n (rst_n),
        .bus     (bus)
`ifdef DRAM_SCHED_STALL_CNT_EN
        ,
        .STALL_CNT (stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase, waiting flag, window index (-1 = none), write flag,
    // awaiting-MREQ-release flag, just-reset flag, stall count.
    int m_ph;
    bit m_wait;
    int m_acc_w;
    bit m_wr;
    bit m_hold;
    bit m_fresh;
    int m_stall;

    task automatic model_reset();
        m_ph = 0; m_wait = 0; m_acc_w = -1; m_wr = 0;
        m_hold = 0; m_fresh = 1; m_stall = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at model ph %0d: observed=%0h expected=%0h", tag, m_ph, obs, exp);
        end
    endtask

    task automatic check_all();
        bit vid, acc;
        vid = (m_ph < 8);
        acc = (m_acc_w >= 0);
        chk("slot_ph",   32'(bus.SLOT_PH), m_ph);
        chk("ras_n",     32'(bus.RAS_n),     ((vid && (m_ph % 4) != 0) || acc) ? 0 : 1);
        chk("cas_n",     32'(bus.CAS_n),     ((vid && (m_ph % 4) >= 2) || (m_acc_w >= 1)) ? 0 : 1);
        chk("mwe_n",     32'(bus.MWE_n),     ((m_acc_w >= 2) && m_wr) ? 0 : 1);
        chk("addr_sel",  32'(bus.ADDR_SEL),  acc ? 1 : 0);
        chk("vid_latch", 32'(bus.VID_LATCH), (vid && (m_ph % 4) == 3) ? 1 : 0);
        chk("cclk",      32'(bus.CCLK),      (vid && !m_fresh) ? 1 : 0);
        chk("wait_n",    32'(bus.WAIT_n),    (m_wait || acc) ? 0 : 1);
`ifdef DRAM_SCHED_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), m_stall);
`endif
    endtask

    // Called at a falling edge: check the current cycle, drive inputs, advance model.
    task automatic step(input logic mreq, input logic rd, input logic wr);
        bit req;
        check_all();
        bus.MREQ_n = mreq;
        bus.RD_n   = rd;
        bus.WR_n   = wr;
        req = !mreq && (!rd || !wr);
        if ((m_wait || m_acc_w >= 0) && m_stall < 65535) m_stall++;
        if (m_acc_w >= 0) begin
            if (m_acc_w == WL - 1) begin
                m_acc_w = -1;
                m_hold  = 1;
            end else begin
                m_acc_w++;
            end
        end else if (m_hold) begin
            if (mreq) m_hold = 0;
        end else if (!req) begin
            m_wait = 0;
        end else if (m_ph == WS - 1) begin
            m_acc_w = 0;
            m_wait  = 0;
            m_wr    = !wr && rd;
        end else begin
            m_wait = 1;
        end
        m_ph    = (m_ph + 1) % 16;
        m_fresh = 0;
        @(negedge clk);
    endtask

    task automatic hold_until(input logic mreq, input logic rd, input logic wr, input int target);
        for (int i = 0; i < 16 && m_ph != target; i++) step(mreq, rd, wr);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1);
    endtask

    logic r_mreq, r_rd, r_wr;

    initial begin
        bus.MREQ_n = 1'b1;
        bus.RD_n   = 1'b1;
        bus.WR_n   = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Video-only slots.
        idle_cycles(32);

        // Read raised in phase 0, held until phase 14.
        hold_until(1'b1, 1'b1, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1);
        hold_until(1'b0, 1'b0, 1'b1, 14);
        idle_cycles(4);

        // Write sampled in phase 7 goes straight to the window.
        hold_until(1'b1, 1'b1, 1'b1, 7);
        step(1'b0, 1'b1, 1'b0);
        hold_until(1'b0, 1'b1, 1'b0, 14);
        idle_cycles(4);

        // Read raised in phase 2 and withdrawn in phase 5.
        hold_until(1'b1, 1'b1, 1'b1, 2);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle_cycles(20);

        // RD and WR both low is a read.
        hold_until(1'b1, 1'b1, 1'b1, 4);
        hold_until(1'b0, 1'b0, 1'b0, 15);
        idle_cycles(4);

        // Reset in phase 10 of a write.
        hold_until(1'b1, 1'b1, 1'b1, 7);
        hold_until(1'b0, 1'b1, 1'b0, 10);
        check_all();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        bus.MREQ_n = 1'b1;
        bus.RD_n   = 1'b1;
        bus.WR_n   = 1'b1;
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        idle_cycles(20);

`ifdef DRAM_SCHED_STALL_CNT_EN
        // Stall count for a read raised in phase 0 right after reset.
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold_until(1'b1, 1'b1, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1);
        hold_until(1'b0, 1'b0, 1'b1, 14);
        chk("stall_after_read", 32'(stall_cnt), 13);
        idle_cycles(4);
`endif

        // Sticky random CPU activity.
        r_mreq = 1'b1; r_rd = 1'b1; r_wr = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                r_mreq = 1'($urandom_range(0, 1));
                r_rd   = 1'($urandom_range(0, 1));
                r_wr   = 1'($urandom_range(0, 1));
            end
            step(r_mreq, r_rd, r_wr);
        end
        idle_cycles(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
